// File: rtl/im_port_arbiter.sv
// Instruction-memory port arbiter: shares one IM port between the fetch path
// (two-cycle registered read) and a loader (single-cycle write).
module im_port_arbiter #(
    parameter logic [31:0] ADDR_START = 32'h0000_3000,
    parameter int unsigned WORDNUM    = 4096,
    localparam int unsigned IDXW      = $clog2(WORDNUM)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [31:0]     if_addr,
    output logic            if_valid,
    output logic [31:0]     if_code,
    output logic            if_fault,
    input  logic            ld_valid,
    input  logic [31:0]     ld_addr,
    input  logic [31:0]     ld_data,
    output logic            ld_ready,
    output logic            ld_err,
    output logic [15:0]     ld_count,
    output logic            mem_en,
    output logic            mem_we,
    output logic [IDXW-1:0] mem_idx,
    output logic [31:0]     mem_wdata,
    input  logic [31:0]     mem_rdata
);

    typedef enum logic {S_IDLE, S_RD} state_t;

    localparam logic [32:0] ADDR_END = {1'b0, ADDR_START} + 33'(WORDNUM) * 33'd4;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        rd_fault_q, rd_fault_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_code_q, if_code_d;
    logic        if_fault_q, if_fault_d;
    logic        ld_err_q, ld_err_d;
    logic [15:0] ld_count_q, ld_count_d;

    logic fetch_ok, ld_ok, contended, fetch_gnt, ld_gnt;

    function automatic logic in_range(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, ADDR_START}) && ({1'b0, a} < ADDR_END) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [IDXW-1:0] to_idx(input logic [31:0] a);
        return IDXW'((a - ADDR_START) >> 2);
    endfunction

    assign fetch_ok  = in_range(if_addr);
    assign ld_ok     = in_range(ld_addr);
    // prio_q = 1 hands a contended slot to the loader; a sole requester always wins
    assign contended = if_req && ld_valid;
    assign fetch_gnt = if_req && !(ld_valid && prio_q);
    assign ld_gnt    = ld_valid && !fetch_gnt;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        rd_fault_d = rd_fault_q;
        if_valid_d = 1'b0;
        if_code_d  = if_code_q;
        if_fault_d = if_fault_q;
        ld_err_d   = ld_err_q;
        ld_count_d = ld_count_q;
        ld_ready   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_idx    = '0;
        mem_wdata  = '0;
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    if (contended) prio_d = ~prio_q;
                    if (fetch_gnt) begin
                        state_d    = S_RD;
                        rd_fault_d = !fetch_ok;
                        if (fetch_ok) begin
                            mem_en  = 1'b1;
                            mem_idx = to_idx(if_addr);
                        end
                    end else if (ld_gnt) begin
                        ld_ready = 1'b1;
                        if (ld_ok) begin
                            mem_en    = 1'b1;
                            mem_we    = 1'b1;
                            mem_idx   = to_idx(ld_addr);
                            mem_wdata = ld_data;
                            if (ld_count_q != 16'hFFFF) ld_count_d = ld_count_q + 16'd1;
                        end else begin
                            ld_err_d = 1'b1;
                        end
                    end
                end
                S_RD: begin
                    state_d    = S_IDLE;
                    if_valid_d = 1'b1;
                    if_fault_d = rd_fault_q;
                    // unknown read data is reported as zero rather than propagated
                    if_code_d  = (rd_fault_q || $isunknown(mem_rdata)) ? '0 : mem_rdata;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            prio_q     <= 1'b0;
            rd_fault_q <= 1'b0;
            if_valid_q <= 1'b0;
            if_code_q  <= '0;
            if_fault_q <= 1'b0;
            ld_err_q   <= 1'b0;
            ld_count_q <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            rd_fault_q <= rd_fault_d;
            if_valid_q <= if_valid_d;
            if_code_q  <= if_code_d;
            if_fault_q <= if_fault_d;
            ld_err_q   <= ld_err_d;
            ld_count_q <= ld_count_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_code  = if_code_q;
    assign if_fault = if_fault_q;
    assign ld_err   = ld_err_q;
    assign ld_count = ld_count_q;

endmodule

// File: tb/tb_im_port_arbiter.sv
// Directed bench for im_port_arbiter with a registered-read IM model.
module tb_im_port_arbiter;

    localparam int unsigned IDXW = 12;

    logic            clk = 1'b0;
    logic            reset;
    logic            if_req;
    logic [31:0]     if_addr;
    logic            if_valid;
    logic [31:0]     if_code;
    logic            if_fault;
    logic            ld_valid;
    logic [31:0]     ld_addr;
    logic [31:0]     ld_data;
    logic            ld_ready;
    logic            ld_err;
    logic [15:0]     ld_count;
    logic            mem_en;
    logic            mem_we;
    logic [IDXW-1:0] mem_idx;
    logic [31:0]     mem_wdata;
    logic [31:0]     mem_rdata;

    logic [31:0] mem [4096];

    int errors = 0;
    int checks = 0;

    im_port_arbiter #(.ADDR_START(32'h0000_3000), .WORDNUM(4096)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_code(if_code), .if_fault(if_fault),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .ld_err(ld_err), .ld_count(ld_count),
        .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_idx] <= mem_wdata;
            else        mem_rdata    <= mem[mem_idx];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] addr, input logic exp_en, input logic [31:0] exp_idx,
                         input logic [31:0] exp_code, input logic exp_fault);
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = addr;
        #1;
        check("fetch_grant_en", 32'(mem_en), 32'(exp_en));
        check("fetch_grant_we", 32'(mem_we), 32'd0);
        check("fetch_grant_idx", 32'(mem_idx), exp_en ? exp_idx : 32'd0);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        check("fetch_rd_en", 32'(mem_en), 32'd0);
        check("fetch_rd_valid", 32'(if_valid), 32'd0);
        @(posedge clk);
        #1;
        check("fetch_valid", 32'(if_valid), 32'd1);
        check("fetch_code", if_code, exp_code);
        check("fetch_fault", 32'(if_fault), 32'(exp_fault));
        @(posedge clk);
        #1;
        check("fetch_valid_pulse", 32'(if_valid), 32'd0);
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data, input logic exp_en,
                        input logic [31:0] exp_idx);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_addr  = addr;
        ld_data  = data;
        #1;
        check("load_ready", 32'(ld_ready), 32'd1);
        check("load_en", 32'(mem_en), 32'(exp_en));
        check("load_we", 32'(mem_we), 32'(exp_en));
        check("load_idx", 32'(mem_idx), exp_en ? exp_idx : 32'd0);
        check("load_wdata", mem_wdata, exp_en ? data : 32'd0);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
    endtask

    // Per-cycle expectations with fetch and loader both held: {ld_ready, mem_en, mem_we, if_valid}
    logic [3:0] contend_exp [6] = '{4'b0100, 4'b0000, 4'b1111, 4'b0100, 4'b0000, 4'b1111};

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[1]    = 32'h2408_0001;
        mem_rdata = '0;
        reset     = 1'b1;
        if_req    = 1'b1;
        if_addr   = 32'h0000_3004;
        ld_valid  = 1'b1;
        ld_addr   = 32'h0000_3008;
        ld_data   = 32'h1234_5678;

        #2;
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        @(posedge clk);
        #1;
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_code", if_code, 32'd0);
        check("rst_if_fault", 32'(if_fault), 32'd0);
        check("rst_ld_err", 32'(ld_err), 32'd0);
        check("rst_ld_count", 32'(ld_count), 32'd0);
        check("rst_ld_ready_hold", 32'(ld_ready), 32'd0);
        @(negedge clk);
        if_req   = 1'b0;
        ld_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("idle_mem_en", 32'(mem_en), 32'd0);
        check("idle_mem_idx", 32'(mem_idx), 32'd0);
        check("idle_mem_wdata", mem_wdata, 32'd0);

        fetch(32'h0000_3004, 1'b1, 32'd1, 32'h2408_0001, 1'b0);
        fetch(32'h0000_3002, 1'b0, 32'd0, 32'd0, 1'b1);
        fetch(32'h0000_2FFC, 1'b0, 32'd0, 32'd0, 1'b1);

        load(32'h0000_3008, 32'hDEAD_BEEF, 1'b1, 32'd2);
        check("load_count1", 32'(ld_count), 32'd1);
        check("load_err0", 32'(ld_err), 32'd0);
        fetch(32'h0000_3008, 1'b1, 32'd2, 32'hDEAD_BEEF, 1'b0);
        fetch(32'h0000_6FFC, 1'b1, 32'd4095, 32'd0, 1'b0);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        if_req   = 1'b1;
        if_addr  = 32'h0000_3004;
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_300C;
        ld_data  = 32'h1111_1111;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("contend_c%0d", c), {28'd0, ld_ready, mem_en, mem_we, if_valid},
                  {28'd0, contend_exp[c]});
            if (contend_exp[c][0]) check($sformatf("contend_code_c%0d", c), if_code, 32'h2408_0001);
            @(negedge clk);
        end
        if_req   = 1'b0;
        ld_valid = 1'b0;
        #1;
        check("contend_count", 32'(ld_count), 32'd2);

        load(32'h0000_7000, 32'hCAFE_F00D, 1'b0, 32'd0);
        check("oob_load_err", 32'(ld_err), 32'd1);
        check("oob_load_count", 32'(ld_count), 32'd2);

        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h0000_3004;
        #1;
        check("rdrst_grant", 32'(mem_en), 32'd1);
        @(negedge clk);
        if_req = 1'b0;
        reset  = 1'b1;
        #1;
        check("rdrst_ld_err", 32'(ld_err), 32'd0);
        check("rdrst_ld_count", 32'(ld_count), 32'd0);
        check("rdrst_mem_en", 32'(mem_en), 32'd0);
        @(posedge clk);
        #1;
        check("rdrst_no_valid", 32'(if_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rdrst_no_valid_after", 32'(if_valid), 32'd0);
        check("rdrst_code", if_code, 32'd0);
        fetch(32'h0000_3004, 1'b1, 32'd1, 32'h2408_0001, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
